// File: rtl/morra_cinese_param_pkg.sv
// Shared encodings, FSM state type and round-outcome function for the Morra Cinese match controller.
package morra_pkg;

    localparam logic [1:0] RIS_NULLA = 2'b00;
    localparam logic [1:0] RIS_P1    = 2'b01;
    localparam logic [1:0] RIS_P2    = 2'b10;
    localparam logic [1:0] RIS_PARI  = 2'b11;

    // DONE encodes as zero so an uninitialised controller idles until the first INIZIA.
    typedef enum logic {
        DONE = 1'b0,
        PLAY = 1'b1
    } stato_t;

    // Outcome of two legal moves a,b in 1..n (n odd): the lower half of the cyclic distance beats.
    function automatic logic [1:0] vince(input int unsigned a, input int unsigned b, input int unsigned n);
        int unsigned d;
        d = (a + n - b) % n;
        if (d == 0)
            return RIS_PARI;
        else if (d <= (n - 1) / 2)
            return RIS_P1;
        else
            return RIS_P2;
    endfunction

endpackage

// File: rtl/morra_cinese_param_if.sv
// Move/result bus between the board (master) and the match controller (slave).
interface morra_cinese_param_if #(
    parameter int unsigned MW = 2
);
    logic [MW-1:0] PRIMO;
    logic [MW-1:0] SECONDO;
    logic [1:0]    MANCHE;
    logic [1:0]    PARTITA;

    modport master (output PRIMO, output SECONDO, input MANCHE, input PARTITA);
    modport slave  (input PRIMO, input SECONDO, output MANCHE, output PARTITA);
endinterface

// File: rtl/morra_cinese_param_arbitro.sv
// Combinational round judge: legality, no-repeat rule for the last winner, then the outcome.
module morra_arbitro
    import morra_pkg::*;
#(
    parameter int unsigned N_MOSSE = 3,
    parameter int unsigned MW      = 2
) (
    input  logic [MW-1:0] primo,
    input  logic [MW-1:0] secondo,
    input  logic          last_valid,
    input  logic          last_p2,
    input  logic [MW-1:0] last_move,
    output logic [1:0]    esito_c
);

    logic legal_c;
    logic repeat_c;

    assign legal_c  = (primo != '0) && (32'(primo) <= N_MOSSE) &&
                      (secondo != '0) && (32'(secondo) <= N_MOSSE);
    assign repeat_c = last_valid && (last_p2 ? (secondo == last_move) : (primo == last_move));
    assign esito_c  = (legal_c && !repeat_c) ? vince(32'(primo), 32'(secondo), N_MOSSE) : RIS_NULLA;

endmodule

// File: rtl/morra_cinese_param.sv
// Match controller: judges one round per clock, tracks wins and ends the match on lead or length.
module morra_cinese_param
    import morra_pkg::*;
#(
    parameter int unsigned N_MOSSE    = 3,
    parameter int unsigned MW         = 2,
    parameter int unsigned MIN_MANCHE = 4,
    parameter int unsigned MAX_MANCHE = 19,
    parameter int unsigned VANTAGGIO  = 2
) (
    input  logic                 clk,
    input  logic                 INIZIA,
    morra_cinese_param_if.slave  bus
);

    localparam int unsigned CW = $clog2(MAX_MANCHE + 1);

    stato_t        state_q, state_d;
    logic [CW-1:0] len_q, len_load_c;
    logic [CW-1:0] giocate_q, giocate_d;
    logic [CW-1:0] wins_p_q, wins_p_d;
    logic [CW-1:0] wins_s_q, wins_s_d;
    logic [CW-1:0] lead_c;
    logic          last_valid_q, last_valid_d;
    logic          last_p2_q, last_p2_d;
    logic [MW-1:0] last_move_q, last_move_d;
    logic [1:0]    manche_q, manche_d;
    logic [1:0]    partita_q, partita_d;
    logic [1:0]    esito_c;
    logic [31:0]   len_sum_c;

    morra_arbitro #(.N_MOSSE(N_MOSSE), .MW(MW)) u_arbitro (
        .primo      (bus.PRIMO),
        .secondo    (bus.SECONDO),
        .last_valid (last_valid_q),
        .last_p2    (last_p2_q),
        .last_move  (last_move_q),
        .esito_c    (esito_c)
    );

    // Match length taken from the concatenated moves while INIZIA is high.
    assign len_sum_c  = 32'(MIN_MANCHE) + 32'({bus.PRIMO, bus.SECONDO});
    assign len_load_c = (len_sum_c > 32'(MAX_MANCHE)) ? CW'(MAX_MANCHE) : CW'(len_sum_c);

    always_comb begin
        state_d      = state_q;
        giocate_d    = giocate_q;
        wins_p_d     = wins_p_q;
        wins_s_d     = wins_s_q;
        last_valid_d = last_valid_q;
        last_p2_d    = last_p2_q;
        last_move_d  = last_move_q;
        manche_d     = RIS_NULLA;
        partita_d    = partita_q;
        lead_c       = '0;
        case (state_q)
            PLAY: begin
                manche_d = esito_c;
                if (esito_c != RIS_NULLA) begin
                    giocate_d = giocate_q + CW'(1);
                    case (esito_c)
                        RIS_P1: begin
                            wins_p_d     = wins_p_q + CW'(1);
                            last_valid_d = 1'b1;
                            last_p2_d    = 1'b0;
                            last_move_d  = bus.PRIMO;
                        end
                        RIS_P2: begin
                            wins_s_d     = wins_s_q + CW'(1);
                            last_valid_d = 1'b1;
                            last_p2_d    = 1'b1;
                            last_move_d  = bus.SECONDO;
                        end
                        default: begin
                            last_valid_d = 1'b0;
                            last_p2_d    = 1'b0;
                            last_move_d  = '0;
                        end
                    endcase
                    // End-of-match test uses the counts including this round.
                    lead_c = (wins_p_d >= wins_s_d) ? (wins_p_d - wins_s_d) : (wins_s_d - wins_p_d);
                    if (((giocate_d >= CW'(MIN_MANCHE)) && (lead_c >= CW'(VANTAGGIO))) ||
                        (giocate_d == len_q)) begin
                        state_d = DONE;
                        if (wins_p_d > wins_s_d)
                            partita_d = RIS_P1;
                        else if (wins_s_d > wins_p_d)
                            partita_d = RIS_P2;
                        else
                            partita_d = RIS_PARI;
                    end
                end
            end
            default: manche_d = RIS_NULLA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (INIZIA) begin
            state_q      <= PLAY;
            len_q        <= len_load_c;
            giocate_q    <= '0;
            wins_p_q     <= '0;
            wins_s_q     <= '0;
            last_valid_q <= 1'b0;
            last_p2_q    <= 1'b0;
            last_move_q  <= '0;
            manche_q     <= RIS_NULLA;
            partita_q    <= RIS_NULLA;
        end else begin
            state_q      <= state_d;
            giocate_q    <= giocate_d;
            wins_p_q     <= wins_p_d;
            wins_s_q     <= wins_s_d;
            last_valid_q <= last_valid_d;
            last_p2_q    <= last_p2_d;
            last_move_q  <= last_move_d;
            manche_q     <= manche_d;
            partita_q    <= partita_d;
        end
    end

    assign bus.MANCHE  = manche_q;
    assign bus.PARTITA = partita_q;

endmodule

// File: tb/tb_morra_cinese_param.sv
// Self-checking bench: directed vector table, hand sequences and randomized rounds vs. a score model.
module tb_morra_cinese_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic inizia  = 1'b0;
    logic inizia5 = 1'b0;

    morra_cinese_param_if #(.MW(2)) bus3 ();
    morra_cinese_param_if #(.MW(3)) bus5 ();

    morra_cinese_param #(.N_MOSSE(3), .MW(2), .MIN_MANCHE(4), .MAX_MANCHE(19), .VANTAGGIO(2)) dut3 (
        .clk    (clk),
        .INIZIA (inizia),
        .bus    (bus3)
    );

    morra_cinese_param #(.N_MOSSE(5), .MW(3), .MIN_MANCHE(4), .MAX_MANCHE(19), .VANTAGGIO(2)) dut5 (
        .clk    (clk),
        .INIZIA (inizia5),
        .bus    (bus5)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         inz;
        int         p;
        int         s;
        logic [1:0] m;
        logic [1:0] pt;
    } vec_t;

    vec_t tbl[$];

    // Score-sheet model of the 3-move game (MIN 4, MAX 19, lead 2).
    bit         m_done    = 1'b1;
    int         m_len     = 0;
    int         m_g       = 0;
    int         m_wp      = 0;
    int         m_ws      = 0;
    int         m_lw      = 0;
    int         m_lm      = 0;
    logic [1:0] m_manche  = 2'b00;
    logic [1:0] m_partita = 2'b00;

    function automatic void model_step(bit inz, int p, int s);
        int d;
        int diff;
        if (inz) begin
            m_done = 1'b0;
            m_len  = 4 + p * 4 + s;
            if (m_len > 19) m_len = 19;
            m_g = 0; m_wp = 0; m_ws = 0; m_lw = 0; m_lm = 0;
            m_manche = 2'b00; m_partita = 2'b00;
            return;
        end
        m_manche = 2'b00;
        if (m_done) return;
        if (p < 1 || p > 3 || s < 1 || s > 3) return;
        if ((m_lw == 1 && p == m_lm) || (m_lw == 2 && s == m_lm)) return;
        d = (((p - s) % 3) + 3) % 3;
        m_g++;
        if (d == 0) begin
            m_manche = 2'b11; m_lw = 0;
        end else if (d == 1) begin
            m_manche = 2'b01; m_wp++; m_lw = 1; m_lm = p;
        end else begin
            m_manche = 2'b10; m_ws++; m_lw = 2; m_lm = s;
        end
        diff = (m_wp > m_ws) ? m_wp - m_ws : m_ws - m_wp;
        if ((m_g >= 4 && diff >= 2) || m_g == m_len) begin
            m_done = 1'b1;
            m_partita = (m_wp > m_ws) ? 2'b01 : (m_ws > m_wp) ? 2'b10 : 2'b11;
        end
    endfunction

    task automatic check(input string name, input logic [1:0] am, input logic [1:0] ap,
                         input logic [1:0] em, input logic [1:0] ep);
        n_tests++;
        if (am !== em || ap !== ep) begin
            n_fail++;
            $display("FAIL %s: MANCHE/PARTITA got %b/%b, expected %b/%b", name, am, ap, em, ep);
        end
    endtask

    task automatic apply3(input bit inz, input int p, input int s);
        inizia      = inz;
        bus3.PRIMO  = 2'(p);
        bus3.SECONDO = 2'(s);
        @(posedge clk);
        #1;
        model_step(inz, p, s);
    endtask

    task automatic apply5(input bit inz, input int p, input int s);
        inizia5      = inz;
        bus5.PRIMO   = 3'(p);
        bus5.SECONDO = 3'(s);
        @(posedge clk);
        #1;
    endtask

    function automatic void add(bit inz, int p, int s, logic [1:0] m, logic [1:0] pt);
        vec_t v;
        v.inz = inz; v.p = p; v.s = s; v.m = m; v.pt = pt;
        tbl.push_back(v);
    endfunction

    initial begin
        bus3.PRIMO = '0; bus3.SECONDO = '0;
        bus5.PRIMO = '0; bus5.SECONDO = '0;
        repeat (2) @(posedge clk);
        #1;

        // Draw match at LEN=4, then moves ignored in DONE.
        add(1, 0, 0, 2'b00, 2'b00);
        add(0, 2, 1, 2'b01, 2'b00);
        add(0, 3, 1, 2'b10, 2'b00);
        add(0, 1, 2, 2'b10, 2'b00);
        add(0, 1, 3, 2'b01, 2'b11);
        add(0, 2, 1, 2'b00, 2'b11);
        // P1 sweep; MANCHE returns to 00 after one DONE cycle.
        add(1, 0, 0, 2'b00, 2'b00);
        add(0, 2, 1, 2'b01, 2'b00);
        add(0, 3, 2, 2'b01, 2'b00);
        add(0, 1, 3, 2'b01, 2'b00);
        add(0, 2, 1, 2'b01, 2'b01);
        add(0, 2, 1, 2'b00, 2'b01);
        add(0, 3, 1, 2'b00, 2'b01);
        // No-repeat rule, cleared by a draw.
        add(1, 0, 0, 2'b00, 2'b00);
        add(0, 2, 1, 2'b01, 2'b00);
        add(0, 2, 3, 2'b00, 2'b00);
        add(0, 3, 2, 2'b01, 2'b00);
        add(0, 1, 1, 2'b11, 2'b00);
        add(0, 3, 2, 2'b01, 2'b01);
        // Illegal moves do not count.
        add(1, 0, 0, 2'b00, 2'b00);
        add(0, 0, 2, 2'b00, 2'b00);
        add(0, 2, 0, 2'b00, 2'b00);
        add(0, 2, 1, 2'b01, 2'b00);

        foreach (tbl[i]) begin
            apply3(tbl[i].inz, tbl[i].p, tbl[i].s);
            check($sformatf("vec%0d", i), bus3.MANCHE, bus3.PARTITA, tbl[i].m, tbl[i].pt);
        end

        // LEN capped at 19: alternating wins plus one draw end exactly on round 19.
        apply3(1, 3, 3);
        check("len19_start", bus3.MANCHE, bus3.PARTITA, 2'b00, 2'b00);
        for (int i = 0; i < 9; i++) begin
            apply3(0, 2, 1);
            check($sformatf("len19_p1_%0d", i), bus3.MANCHE, bus3.PARTITA, 2'b01, 2'b00);
            apply3(0, 1, 2);
            check($sformatf("len19_p2_%0d", i), bus3.MANCHE, bus3.PARTITA, 2'b10, 2'b00);
        end
        apply3(0, 3, 3);
        check("len19_last", bus3.MANCHE, bus3.PARTITA, 2'b11, 2'b11);
        apply3(0, 2, 1);
        check("len19_hold", bus3.MANCHE, bus3.PARTITA, 2'b00, 2'b11);

        // Abort mid-match, then four draws at LEN=4.
        apply3(1, 0, 0);
        apply3(0, 1, 2);
        check("abort_r1", bus3.MANCHE, bus3.PARTITA, 2'b10, 2'b00);
        apply3(0, 2, 3);
        check("abort_r2", bus3.MANCHE, bus3.PARTITA, 2'b10, 2'b00);
        apply3(0, 3, 1);
        check("abort_r3", bus3.MANCHE, bus3.PARTITA, 2'b10, 2'b00);
        apply3(1, 0, 0);
        check("abort_clr", bus3.MANCHE, bus3.PARTITA, 2'b00, 2'b00);
        apply3(0, 1, 1);
        check("draw_1", bus3.MANCHE, bus3.PARTITA, 2'b11, 2'b00);
        apply3(0, 2, 2);
        check("draw_2", bus3.MANCHE, bus3.PARTITA, 2'b11, 2'b00);
        apply3(0, 3, 3);
        check("draw_3", bus3.MANCHE, bus3.PARTITA, 2'b11, 2'b00);
        apply3(0, 1, 1);
        check("draw_4", bus3.MANCHE, bus3.PARTITA, 2'b11, 2'b11);

        // Five-move variant.
        apply5(1, 0, 0);
        check("n5_start", bus5.MANCHE, bus5.PARTITA, 2'b00, 2'b00);
        apply5(0, 1, 5);
        check("n5_1v5", bus5.MANCHE, bus5.PARTITA, 2'b01, 2'b00);
        apply5(0, 4, 4);
        check("n5_4v4", bus5.MANCHE, bus5.PARTITA, 2'b11, 2'b00);
        apply5(0, 1, 3);
        check("n5_1v3", bus5.MANCHE, bus5.PARTITA, 2'b10, 2'b00);
        apply5(0, 6, 1);
        check("n5_6v1", bus5.MANCHE, bus5.PARTITA, 2'b00, 2'b00);

        // Randomized matches against the model, occasional restarts with random length.
        apply3(1, $urandom_range(0, 3), $urandom_range(0, 3));
        check("rand_start", bus3.MANCHE, bus3.PARTITA, m_manche, m_partita);
        for (int i = 0; i < 2000; i++) begin
            bit inz;
            int p;
            int s;
            inz = ($urandom_range(0, 39) == 0);
            p   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            s   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            if (inz) begin
                p = $urandom_range(0, 3);
                s = $urandom_range(0, 3);
            end
            apply3(inz, p, s);
            check($sformatf("rand%0d", i), bus3.MANCHE, bus3.PARTITA, m_manche, m_partita);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
